// File: rtl/knn_topk_ctrl.sv
// -----------------------------------------------------------------------------
// knn_topk_ctrl
// Sequencer that keeps the k smallest-distance candidates in an external
// double-ended, tag-ordered queue and drains them smallest-first at the end of
// the candidate stream.
//
// Phases: FILL enqueues until k elements are held. CMP compares each new tag
// against the queue maximum; a strictly smaller tag evicts the largest entry
// and is inserted in its place. DRAIN pops the smallest entry repeatedly onto
// the result port.
//
// Optional feature: define KNN_CTRL_WATCHDOG_EN to build a watchdog on the two
// queue-wait states (parameter WDOG_CYCLES). Without it the wait states wait
// indefinitely and error_out stays 0.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-low reset
//   start_in, k_in          search start pulse, neighbours wanted (clamped 1..DEPTH)
//   cand_*                  candidate stream (valid/ready, data, tag, last)
//   q_enq_out, q_deq_*_out  queue command pulses (at most one per cycle)
//   q_enq_data/tag_out      enqueue payload
//   q_valid/data/tag_in     queue dequeue result
//   q_max_tag_in            current largest tag held by the queue
//   res_*                   result stream (valid/ready, data, tag, last)
//   busy_out, done_out      busy level, one-cycle completion pulse
//   evict_cnt_out           replacements this search (saturating)
//   error_out               sticky watchdog error
// -----------------------------------------------------------------------------
module knn_topk_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 32,
  parameter int DEPTH         = 8,
  parameter int SETTLE_CYCLES = 10
`ifdef KNN_CTRL_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES   = 64
`endif
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic [$clog2(DEPTH):0]  k_in,
  input  logic                    cand_valid_in,
  output logic                    cand_ready_out,
  input  logic [DATA_WIDTH-1:0]   cand_data_in,
  input  logic [TAG_WIDTH-1:0]    cand_tag_in,
  input  logic                    cand_last_in,
  output logic                    q_enq_out,
  output logic                    q_deq_largest_out,
  output logic                    q_deq_smallest_out,
  output logic [DATA_WIDTH-1:0]   q_enq_data_out,
  output logic [TAG_WIDTH-1:0]    q_enq_tag_out,
  input  logic                    q_valid_in,
  input  logic [DATA_WIDTH-1:0]   q_data_in,
  input  logic [TAG_WIDTH-1:0]    q_tag_in,
  input  logic [TAG_WIDTH-1:0]    q_max_tag_in,
  output logic                    res_valid_out,
  input  logic                    res_ready_in,
  output logic [DATA_WIDTH-1:0]   res_data_out,
  output logic [TAG_WIDTH-1:0]    res_tag_out,
  output logic                    res_last_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [15:0]             evict_cnt_out,
  output logic                    error_out
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C       = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 32'sd1);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FILL       = 4'd1,
    S_ENQ        = 4'd2,
    S_GAP        = 4'd3,
    S_CMP        = 4'd4,
    S_EVICT_REQ  = 4'd5,
    S_EVICT_WAIT = 4'd6,
    S_INSERT     = 4'd7,
    S_SETTLE     = 4'd8,
    S_DRAIN_REQ  = 4'd9,
    S_DRAIN_WAIT = 4'd10,
    S_DRAIN_OUT  = 4'd11,
    S_DONE       = 4'd12
  } state_t;

  state_t state_r, state_nxt_s, ret_r;

  logic [CW-1:0]         k_r, cnt_r;
  logic [SW-1:0]         settle_r;
  logic                  hold_last_r;
  logic [DATA_WIDTH-1:0] enq_data_r, res_data_r;
  logic [TAG_WIDTH-1:0]  enq_tag_r, res_tag_r;
  logic                  res_valid_r, res_last_r;
  logic [15:0]           evict_r;

  logic ready_r, busy_r, q_enq_r, q_deq_large_r, q_deq_small_r, done_r, error_r;
  logic ready_d, busy_d, q_enq_d, q_deq_large_d, q_deq_small_d, done_d, error_d;

  logic accept_s, keep_s, wdog_fire_s;

  // Clamp the requested neighbour count into the legal range 1..DEPTH.
  function automatic logic [CW-1:0] clamp_k(input logic [CW-1:0] k_raw);
    logic [CW-1:0] k_v;
    if (k_raw == {CW{1'b0}}) begin
      k_v = ONE_C;
    end else if (k_raw > DEPTH_C) begin
      k_v = DEPTH_C;
    end else begin
      k_v = k_raw;
    end
    return k_v;
  endfunction

  assign accept_s = cand_valid_in & ready_r;
  // Strictly smaller only: on a tie the element already in the queue wins.
  assign keep_s   = (cand_tag_in < q_max_tag_in);

`ifdef KNN_CTRL_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_r;
  logic          in_wait_s;

  assign in_wait_s   = (state_r == S_EVICT_WAIT) || (state_r == S_DRAIN_WAIT);
  // A response arriving in the final counted cycle still wins over the timeout.
  assign wdog_fire_s = in_wait_s && !q_valid_in && (wdog_r == WW'(WDOG_CYCLES - 32'sd1));

  // Watchdog: counts consecutive cycles spent in a queue-wait state.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wdog_r <= {WW{1'b0}};
    end else if (in_wait_s) begin
      wdog_r <= wdog_r + {{(WW-1){1'b0}}, 1'b1};
    end else begin
      wdog_r <= {WW{1'b0}};
    end
  end
`else
  assign wdog_fire_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:       state_nxt_s = start_in ? S_FILL : S_IDLE;
      S_FILL:       state_nxt_s = accept_s ? S_ENQ : S_FILL;
      S_ENQ:        state_nxt_s = S_GAP;
      S_GAP: begin
        if (hold_last_r) begin
          state_nxt_s = S_DRAIN_REQ;
        end else if (cnt_r == k_r) begin
          state_nxt_s = S_CMP;
        end else begin
          state_nxt_s = S_FILL;
        end
      end
      S_CMP: begin
        if (!accept_s) begin
          state_nxt_s = S_CMP;
        end else if (keep_s) begin
          state_nxt_s = S_EVICT_REQ;
        end else if (cand_last_in) begin
          state_nxt_s = S_DRAIN_REQ;
        end else begin
          state_nxt_s = S_CMP;
        end
      end
      S_EVICT_REQ:  state_nxt_s = S_EVICT_WAIT;
      S_EVICT_WAIT: begin
        if (q_valid_in) begin
          state_nxt_s = S_INSERT;
        end else if (wdog_fire_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_EVICT_WAIT;
        end
      end
      S_INSERT:     state_nxt_s = S_SETTLE;
      S_SETTLE:     state_nxt_s = (settle_r == {SW{1'b0}}) ? ret_r : S_SETTLE;
      S_DRAIN_REQ:  state_nxt_s = (cnt_r == {CW{1'b0}}) ? S_DONE : S_DRAIN_WAIT;
      S_DRAIN_WAIT: begin
        if (q_valid_in) begin
          state_nxt_s = S_DRAIN_OUT;
        end else if (wdog_fire_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_DRAIN_WAIT;
        end
      end
      S_DRAIN_OUT:  state_nxt_s = res_ready_in ? S_SETTLE : S_DRAIN_OUT;
      S_DONE:       state_nxt_s = S_IDLE;
      default:      state_nxt_s = S_IDLE;
    endcase
  end

  // Output decode from the next state, so every output leaves a flop.
  // cnt_r is stable across the entry into DRAIN_REQ, so it decides the pop.
  always_comb begin
    ready_d       = (state_nxt_s == S_FILL) || (state_nxt_s == S_CMP);
    busy_d        = (state_nxt_s != S_IDLE);
    q_enq_d       = (state_nxt_s == S_ENQ) || (state_nxt_s == S_INSERT);
    q_deq_large_d = (state_nxt_s == S_EVICT_REQ);
    q_deq_small_d = (state_nxt_s == S_DRAIN_REQ) && (cnt_r != {CW{1'b0}});
    done_d        = (state_nxt_s == S_DONE);
    error_d       = error_r | wdog_fire_s;
  end

  // Output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ready_r       <= 1'b0;
      busy_r        <= 1'b0;
      q_enq_r       <= 1'b0;
      q_deq_large_r <= 1'b0;
      q_deq_small_r <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      ready_r       <= ready_d;
      busy_r        <= busy_d;
      q_enq_r       <= q_enq_d;
      q_deq_large_r <= q_deq_large_d;
      q_deq_small_r <= q_deq_small_d;
      done_r        <= done_d;
      error_r       <= error_d;
    end
  end

  // Search bookkeeping: k, occupancy, held candidate and eviction count.
  // Evict-then-insert leaves occupancy unchanged, so cnt_r is untouched there.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      k_r         <= {CW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      hold_last_r <= 1'b0;
      enq_data_r  <= {DATA_WIDTH{1'b0}};
      enq_tag_r   <= {TAG_WIDTH{1'b0}};
      evict_r     <= 16'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_in) begin
            k_r         <= clamp_k(k_in);
            cnt_r       <= {CW{1'b0}};
            hold_last_r <= 1'b0;
            evict_r     <= 16'd0;
          end
        end
        S_FILL: begin
          if (accept_s) begin
            enq_data_r  <= cand_data_in;
            enq_tag_r   <= cand_tag_in;
            hold_last_r <= cand_last_in;
            cnt_r       <= cnt_r + ONE_C;
          end
        end
        S_CMP: begin
          if (accept_s && keep_s) begin
            enq_data_r  <= cand_data_in;
            enq_tag_r   <= cand_tag_in;
            hold_last_r <= cand_last_in;
          end
        end
        S_EVICT_WAIT: begin
          if (q_valid_in && (evict_r != 16'hFFFF)) begin
            evict_r <= evict_r + 16'd1;
          end
        end
        S_DRAIN_WAIT: begin
          if (q_valid_in) begin
            cnt_r <= cnt_r - ONE_C;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Settle timer and the state it returns to.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      settle_r <= {SW{1'b0}};
      ret_r    <= S_IDLE;
    end else if (state_r == S_INSERT) begin
      settle_r <= SETTLE_LOAD;
      ret_r    <= hold_last_r ? S_DRAIN_REQ : S_CMP;
    end else if ((state_r == S_DRAIN_OUT) && res_ready_in) begin
      settle_r <= SETTLE_LOAD;
      ret_r    <= S_DRAIN_REQ;
    end else if ((state_r == S_SETTLE) && (settle_r != {SW{1'b0}})) begin
      settle_r <= settle_r - {{(SW-1){1'b0}}, 1'b1};
    end else begin
      settle_r <= settle_r;
    end
  end

  // Result registers: loaded from the queue, held until the consumer takes them.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      res_valid_r <= 1'b0;
      res_last_r  <= 1'b0;
      res_data_r  <= {DATA_WIDTH{1'b0}};
      res_tag_r   <= {TAG_WIDTH{1'b0}};
    end else if ((state_r == S_DRAIN_WAIT) && q_valid_in) begin
      res_valid_r <= 1'b1;
      res_last_r  <= (cnt_r == ONE_C);
      res_data_r  <= q_data_in;
      res_tag_r   <= q_tag_in;
    end else if ((state_r == S_DRAIN_OUT) && res_ready_in) begin
      res_valid_r <= 1'b0;
      res_last_r  <= 1'b0;
    end else begin
      res_valid_r <= res_valid_r;
      res_last_r  <= res_last_r;
    end
  end

  assign cand_ready_out     = ready_r;
  assign busy_out           = busy_r;
  assign q_enq_out          = q_enq_r;
  assign q_deq_largest_out  = q_deq_large_r;
  assign q_deq_smallest_out = q_deq_small_r;
  assign q_enq_data_out     = enq_data_r;
  assign q_enq_tag_out      = enq_tag_r;
  assign res_valid_out      = res_valid_r;
  assign res_last_out       = res_last_r;
  assign res_data_out       = res_data_r;
  assign res_tag_out        = res_tag_r;
  assign done_out           = done_r;
  assign evict_cnt_out      = evict_r;
  assign error_out          = error_r;

endmodule

// File: tb/tb_knn_topk_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for knn_topk_ctrl: behavioural tag-ordered queue with a two-cycle
// dequeue latency, a top-k reference model feeding a result scoreboard, and
// directed scenarios (fill/replace, short stream, ties, back-pressure, k
// clamping, stalled queue with reset, watchdog when KNN_CTRL_WATCHDOG_EN).
// -----------------------------------------------------------------------------
module tb_knn_topk_ctrl;
  localparam int DW    = 32;
  localparam int TW    = 32;
  localparam int DEPTH = 8;
  localparam int KW    = $clog2(DEPTH) + 1;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [KW-1:0] k_in;
  logic          cand_valid_in, cand_ready_out, cand_last_in;
  logic [DW-1:0] cand_data_in;
  logic [TW-1:0] cand_tag_in;
  logic          q_enq_out, q_deq_largest_out, q_deq_smallest_out;
  logic [DW-1:0] q_enq_data_out;
  logic [TW-1:0] q_enq_tag_out;
  logic          q_valid_in;
  logic [DW-1:0] q_data_in;
  logic [TW-1:0] q_tag_in, q_max_tag_in;
  logic          res_valid_out, res_ready_in, res_last_out;
  logic [DW-1:0] res_data_out;
  logic [TW-1:0] res_tag_out;
  logic          busy_out, done_out, error_out;
  logic [15:0]   evict_cnt_out;

  always #5 clk_in = ~clk_in;

  knn_topk_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .k_in(k_in),
    .cand_valid_in(cand_valid_in), .cand_ready_out(cand_ready_out),
    .cand_data_in(cand_data_in), .cand_tag_in(cand_tag_in), .cand_last_in(cand_last_in),
    .q_enq_out(q_enq_out), .q_deq_largest_out(q_deq_largest_out),
    .q_deq_smallest_out(q_deq_smallest_out),
    .q_enq_data_out(q_enq_data_out), .q_enq_tag_out(q_enq_tag_out),
    .q_valid_in(q_valid_in), .q_data_in(q_data_in), .q_tag_in(q_tag_in),
    .q_max_tag_in(q_max_tag_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .res_data_out(res_data_out), .res_tag_out(res_tag_out), .res_last_out(res_last_out),
    .busy_out(busy_out), .done_out(done_out), .evict_cnt_out(evict_cnt_out),
    .error_out(error_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural queue (insertion order kept) ----------------
  logic [DW-1:0] qm_d[$];
  logic [TW-1:0] qm_t[$];
  bit            q_mute = 1'b0;
  logic          p1_v, p2_v;
  logic [DW-1:0] p1_d, p2_d;
  logic [TW-1:0] p1_t, p2_t;

  initial begin
    int idx;
    q_valid_in = 1'b0; q_data_in = '0; q_tag_in = '0; q_max_tag_in = '0;
    p1_v = 1'b0; p2_v = 1'b0; p1_d = '0; p2_d = '0; p1_t = '0; p2_t = '0;
    forever begin
      @(posedge clk_in); #1;
      if (!rst_in) begin
        qm_d.delete(); qm_t.delete();
        p1_v = 1'b0; p2_v = 1'b0; q_valid_in = 1'b0; q_max_tag_in = '0;
      end else begin
        q_valid_in = p2_v; q_data_in = p2_d; q_tag_in = p2_t;
        p2_v = p1_v; p2_d = p1_d; p2_t = p1_t; p1_v = 1'b0;
        if (q_enq_out) begin
          qm_d.push_back(q_enq_data_out); qm_t.push_back(q_enq_tag_out);
        end
        if ((q_deq_largest_out || q_deq_smallest_out) && qm_t.size() > 0) begin
          idx = 0;
          for (int i = 1; i < qm_t.size(); i++) begin
            if (q_deq_largest_out ? (qm_t[i] >= qm_t[idx]) : (qm_t[i] < qm_t[idx])) idx = i;
          end
          p1_d = qm_d[idx]; p1_t = qm_t[idx]; p1_v = !q_mute;
          qm_d.delete(idx); qm_t.delete(idx);
        end
        q_max_tag_in = '0;
        for (int i = 0; i < qm_t.size(); i++) begin
          if (qm_t[i] > q_max_tag_in) q_max_tag_in = qm_t[i];
        end
      end
    end
  end

  // ---------------- pulse monitors ----------------
  int done_cnt = 0, lg_cnt = 0, sm_cnt = 0;
  initial begin
    forever begin
      @(negedge clk_in);
      if (done_out) done_cnt++;
      if (q_deq_largest_out) lg_cnt++;
      if (q_deq_smallest_out) sm_cnt++;
    end
  end

  // ---------------- scoreboard and directed search ----------------
  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic          l;
  } res_t;
  res_t exp_q[$];
  int   stim_tag[$];
  int   search_id = 0;

  task automatic send(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic l);
    int n = 0;
    cand_valid_in = 1'b1; cand_data_in = d; cand_tag_in = t; cand_last_in = l;
    while (!cand_ready_out && n < 2000) begin @(posedge clk_in); #1; n++; end
    chk("cand_ready_wait", n < 2000, 1'b1);
    @(posedge clk_in); #1;
    cand_valid_in = 1'b0; cand_last_in = 1'b0;
  endtask

  task automatic pulse_start(input int k);
    start_in = 1'b1; k_in = KW'(k);
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  task automatic run_search(input int k, input int hold_cycles);
    logic [DW-1:0] md[$];
    logic [TW-1:0] mt[$];
    logic [DW-1:0] d;
    int   kk, idx, n, exp_ev, done_base, lg_base, sm_base;
    bit   first;
    res_t e;
    exp_ev = 0;
    kk = (k < 1) ? 1 : ((k > DEPTH) ? DEPTH : k);
    // reference top-k: replace the newest largest entry when strictly beaten
    for (int i = 0; i < stim_tag.size(); i++) begin
      d = 32'hA000_0000 | (32'(search_id) << 8) | 32'(i);
      if (mt.size() < kk) begin
        md.push_back(d); mt.push_back(TW'(stim_tag[i]));
      end else begin
        idx = 0;
        for (int j = 1; j < mt.size(); j++) if (mt[j] >= mt[idx]) idx = j;
        if (TW'(stim_tag[i]) < mt[idx]) begin
          md.delete(idx); mt.delete(idx);
          md.push_back(d); mt.push_back(TW'(stim_tag[i]));
          exp_ev++;
        end
      end
    end
    while (mt.size() > 0) begin
      idx = 0;
      for (int j = 1; j < mt.size(); j++) if (mt[j] < mt[idx]) idx = j;
      exp_q.push_back('{md[idx], mt[idx], mt.size() == 1});
      md.delete(idx); mt.delete(idx);
    end

    done_base = done_cnt; lg_base = lg_cnt;
    pulse_start(k);
    for (int i = 0; i < stim_tag.size(); i++) begin
      d = 32'hA000_0000 | (32'(search_id) << 8) | 32'(i);
      send(d, TW'(stim_tag[i]), i == stim_tag.size() - 1);
    end

    first = 1'b1;
    while (exp_q.size() > 0) begin
      n = 0;
      while (!res_valid_out && n < 2000) begin @(posedge clk_in); #1; n++; end
      chk("res_valid_wait", n < 2000, 1'b1);
      e = exp_q.pop_front();
      chk("res_data", res_data_out, e.d);
      chk("res_tag", res_tag_out, e.t);
      chk("res_last", res_last_out, e.l);
      if (first && hold_cycles > 0) begin
        sm_base = sm_cnt;
        for (int c = 0; c < hold_cycles; c++) begin
          @(posedge clk_in); #1;
          chk("hold_valid", res_valid_out, 1'b1);
          chk("hold_data", res_data_out, e.d);
          chk("hold_tag", res_tag_out, e.t);
        end
        @(negedge clk_in); #1;
        chk("hold_no_extra_deq", sm_cnt - sm_base, 0);
      end
      first = 1'b0;
      res_ready_in = 1'b1;
      @(posedge clk_in); #1;
      res_ready_in = 1'b0;
      chk("res_valid_drop", res_valid_out, 1'b0);
    end

    n = 0;
    while (!done_out && n < 2000) begin @(posedge clk_in); #1; n++; end
    chk("done_wait", n < 2000, 1'b1);
    chk("evict_cnt", evict_cnt_out, exp_ev);
    @(posedge clk_in); #1;
    chk("busy_after_done", busy_out, 1'b0);
    chk("evict_cnt_hold", evict_cnt_out, exp_ev);
    @(negedge clk_in); #1;
    chk("done_pulses", done_cnt - done_base, 1);
    chk("deq_largest_cmds", lg_cnt - lg_base, exp_ev);
    search_id++;
  endtask

  // Drive a search into EVICT_WAIT with a queue that never answers.
  task automatic stall_in_evict_wait();
    int n = 0;
    q_mute = 1'b1;
    pulse_start(1);
    send(32'hBEEF_0001, 32'd50, 1'b0);
    send(32'hBEEF_0002, 32'd10, 1'b0);
    while (!q_deq_largest_out && n < 200) begin @(posedge clk_in); #1; n++; end
    chk("stall_evict_req", q_deq_largest_out, 1'b1);
  endtask

  initial begin
    rst_in = 1'b0; start_in = 1'b0; k_in = '0;
    cand_valid_in = 1'b0; cand_data_in = '0; cand_tag_in = '0; cand_last_in = 1'b0;
    res_ready_in = 1'b0;

    // reset state
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_ctrl", {cand_ready_out, q_enq_out, q_deq_largest_out, q_deq_smallest_out,
                     res_valid_out, res_last_out, busy_out, done_out, error_out}, 128'd0);
    chk("rst_payload", {q_enq_data_out, q_enq_tag_out, res_data_out, res_tag_out}, 128'd0);
    chk("rst_evict", evict_cnt_out, 16'd0);
    #2 rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("idle_busy", busy_out, 1'b0);

    // fill then two replacements
    stim_tag = '{50, 20, 40, 10, 30};
    run_search(3, 0);
    // stream shorter than k
    stim_tag = '{7, 3, 9};
    run_search(4, 0);
    // ties keep the earlier elements
    stim_tag = '{5, 5, 5, 5};
    run_search(2, 0);
    // consumer back-pressure on the first result
    stim_tag = '{9, 3, 6};
    run_search(2, 20);
    // k clamping: 0 -> 1, 15 -> DEPTH
    stim_tag = '{4, 2};
    run_search(0, 0);
    stim_tag = '{90, 80, 70, 60, 50, 40, 30, 20, 10};
    run_search(15, 0);

    // stalled queue response
    stall_in_evict_wait();
`ifdef KNN_CTRL_WATCHDOG_EN
    for (int i = 1; i <= 66; i++) begin
      @(posedge clk_in); #1;
      if (i == 64) chk("wdog_not_yet", error_out, 1'b0);
      if (i == 65) begin
        chk("wdog_error", error_out, 1'b1);
        chk("wdog_done", done_out, 1'b1);
      end
      if (i == 66) chk("wdog_idle", busy_out, 1'b0);
    end
    stall_in_evict_wait();
    chk("wdog_sticky", error_out, 1'b1);
`else
    repeat (80) @(posedge clk_in);
    #1;
    chk("stall_busy", busy_out, 1'b0 == 1'b0 ? busy_out & 1'b1 : 1'b0);
    chk("stall_no_error", error_out, 1'b0);
    chk("stall_still_busy", busy_out, 1'b1);
`endif
    // asynchronous reset in the middle of EVICT_WAIT
    repeat (10) @(posedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("mid_rst_ctrl", {cand_ready_out, q_enq_out, q_deq_largest_out, q_deq_smallest_out,
                         res_valid_out, res_last_out, busy_out, done_out, error_out}, 128'd0);
    chk("mid_rst_payload", {q_enq_data_out, q_enq_tag_out, res_data_out, res_tag_out}, 128'd0);
    chk("mid_rst_evict", evict_cnt_out, 16'd0);
    repeat (2) @(posedge clk_in);
    #3 rst_in = 1'b1;
    q_mute = 1'b0;
    @(posedge clk_in); #1;

    // normal search after reset
    stim_tag = '{8, 4, 6};
    run_search(2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
